// File: rtl/transmitter_pkg.sv
// Shared constants, sample type and arithmetic helpers for the QPSK transmitter.
package transmitter_pkg;

    localparam int DATA_W      = 7;
    localparam int DATA_TAP_A  = 6;
    localparam int DATA_TAP_B  = 5;
    localparam int NOISE_W     = 15;
    localparam int NOISE_TAP_A = 14;
    localparam int NOISE_TAP_B = 13;

    typedef logic signed [3:0] qpsk_level_t;

    // Clamp a 5-bit sum into the 4-bit channel range [-8,+7].
    function automatic qpsk_level_t sat4(input logic signed [4:0] v);
        if (v > 5'sd7) begin
            return 4'sd7;
        end
        if (v < -5'sd8) begin
            return -4'sd8;
        end
        return v[3:0];
    endfunction

    // 2-bit noise field to impairment: 01 -> +1, 10 -> -1, 00/11 -> 0.
    function automatic qpsk_level_t noise_map(input logic [1:0] f);
        case (f)
            2'b01:   return 4'sd1;
            2'b10:   return -4'sd1;
            default: return 4'sd0;
        endcase
    endfunction

endpackage

// File: rtl/transmitter_if.sv
// Control inputs and channel sample outputs of the transmitter.
interface transmitter_if;
    import transmitter_pkg::*;

    logic        has_error;
    logic        IsTransmit;
    qpsk_level_t channel_outI;
    qpsk_level_t channel_outQ;

    // master: the transmitter sourcing the channel; slave: whoever drives/consumes it.
    modport master (input has_error, input IsTransmit,
                    output channel_outI, output channel_outQ);
    modport slave  (output has_error, output IsTransmit,
                    input channel_outI, input channel_outQ);
endinterface

// File: rtl/transmitter_lfsr_gen.sv
// Fibonacci LFSR, shift-left form {s[W-2:0], s[TAP_A]^s[TAP_B]}, optionally two steps per enable.
// Latency: state updates on the enabled edge; no backpressure beyond the enable.
// Exposes only the low OUT_W bits, which is all the consumers need.
module lfsr_gen #(
    parameter int               WIDTH = 7,
    parameter int               TAP_A = 6,
    parameter int               TAP_B = 5,
    parameter logic [WIDTH-1:0] SEED  = {WIDTH{1'b1}},
    parameter bit               STEP2 = 1'b0,
    parameter int               OUT_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic [OUT_W-1:0] low_bits
);

    logic [WIDTH-1:0] state;
    logic [WIDTH-1:0] state_nxt;

    function automatic logic [WIDTH-1:0] step(input logic [WIDTH-1:0] s);
        return {s[WIDTH-2:0], s[TAP_A] ^ s[TAP_B]};
    endfunction

    always_comb begin
        state_nxt = step(state);
        if (STEP2) begin
            state_nxt = step(step(state));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= SEED;
        end else if (en) begin
            state <= state_nxt;
        end
    end

    assign low_bits = state[OUT_W-1:0];

endmodule

// File: rtl/transmitter.sv
// QPSK baseband source: PRBS7 bits -> +/-AMP I/Q symbols held SYM_DIV clocks, optional +/-1 impairment.
// Latency: symbol loads on the counter==0 edge and reaches channel_outI/Q one edge later.
// Backpressure: IsTransmit=0 freezes counter, data LFSR and symbol; outputs read 0 while paused.
module transmitter
    import transmitter_pkg::*;
#(
    parameter int         SYM_DIV    = 4,
    parameter int         AMP        = 3,
    parameter logic [6:0] PRBS_SEED  = 7'h7F,
    parameter logic [14:0] NOISE_SEED = 15'h0001
) (
    input  logic          sys_clk,
    input  logic          reset,
    transmitter_if.master tx
);

    localparam int          CNT_W   = $clog2(SYM_DIV);
    localparam qpsk_level_t LVL_POS = 4'(AMP);
    localparam qpsk_level_t LVL_NEG = 4'(-AMP);

    logic [CNT_W-1:0] sym_cnt;
    logic             sym_load;
    logic             sym_last;
    logic [1:0]       data_bits;
    logic [3:0]       noise_bits;
    qpsk_level_t      sym_i;
    qpsk_level_t      sym_q;
    qpsk_level_t      noise_i;
    qpsk_level_t      noise_q;
    logic signed [4:0] sum_i;
    logic signed [4:0] sum_q;

    assign sym_load = tx.IsTransmit && (sym_cnt == '0);
    assign sym_last = (sym_cnt == CNT_W'(SYM_DIV - 1));

    // Two data bits are consumed per symbol, so the data LFSR steps twice per load.
    lfsr_gen #(
        .WIDTH (DATA_W),
        .TAP_A (DATA_TAP_A),
        .TAP_B (DATA_TAP_B),
        .SEED  (PRBS_SEED),
        .STEP2 (1'b1),
        .OUT_W (2)
    ) u_data_lfsr (
        .clk      (sys_clk),
        .rst_n    (reset),
        .en       (sym_load),
        .low_bits (data_bits)
    );

    // Noise runs freely so the impairment pattern is independent of pausing.
    lfsr_gen #(
        .WIDTH (NOISE_W),
        .TAP_A (NOISE_TAP_A),
        .TAP_B (NOISE_TAP_B),
        .SEED  (NOISE_SEED),
        .STEP2 (1'b0),
        .OUT_W (4)
    ) u_noise_lfsr (
        .clk      (sys_clk),
        .rst_n    (reset),
        .en       (1'b1),
        .low_bits (noise_bits)
    );

    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            sym_cnt <= '0;
        end else if (tx.IsTransmit) begin
            sym_cnt <= sym_last ? '0 : sym_cnt + 1'b1;
        end
    end

    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            sym_i <= '0;
            sym_q <= '0;
        end else if (sym_load) begin
            sym_i <= data_bits[1] ? LVL_NEG : LVL_POS;
            sym_q <= data_bits[0] ? LVL_NEG : LVL_POS;
        end
    end

    always_comb begin
        noise_i = '0;
        noise_q = '0;
        if (tx.has_error) begin
            noise_i = noise_map(noise_bits[1:0]);
            noise_q = noise_map(noise_bits[3:2]);
        end
        sum_i = {sym_i[3], sym_i} + {noise_i[3], noise_i};
        sum_q = {sym_q[3], sym_q} + {noise_q[3], noise_q};
    end

    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            tx.channel_outI <= '0;
            tx.channel_outQ <= '0;
        end else if (tx.IsTransmit) begin
            tx.channel_outI <= sat4(sum_i);
            tx.channel_outQ <= sat4(sum_q);
        end else begin
            tx.channel_outI <= '0;
            tx.channel_outQ <= '0;
        end
    end

endmodule

// File: tb/tb_transmitter.sv
// Randomised bench for transmitter: recurrence-based PRBS/noise model, per-cycle compare, literal pins.
module tb_transmitter;

    localparam int SD = 4;
    localparam int ND = 1600;
    localparam int NN = 4000;

    logic sys_clk = 1'b0;
    logic reset   = 1'b1;
    logic has_error = 1'b0;
    logic is_tx     = 1'b1;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;
    bit cov_en   = 1'b0;
    int phase    = 0;
    bit seen_p, seen_n, sat_hi_seen, sat_lo_seen;

    bit darr [ND];
    bit narr [NN];

    transmitter_if if3 ();
    transmitter_if if7 ();

    assign if3.has_error  = has_error;
    assign if3.IsTransmit = is_tx;
    assign if7.has_error  = has_error;
    assign if7.IsTransmit = is_tx;

    transmitter #(.SYM_DIV(SD), .AMP(3)) u_dut (
        .sys_clk (sys_clk),
        .reset   (reset),
        .tx      (if3.master)
    );

    transmitter #(.SYM_DIV(SD), .AMP(7)) u_dut7 (
        .sys_clk (sys_clk),
        .reset   (reset),
        .tx      (if7.master)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // Bit recurrence x[n] = x[n-7] ^ x[n-6]; symbol j uses bits 2j+5 (I) and 2j+6 (Q).
    function automatic int sym_lvl(input int j, input bit is_q, input int amp);
        bit b;
        b = is_q ? darr[2*j+6] : darr[2*j+5];
        return b ? -amp : amp;
    endfunction

    // Noise recurrence y[n] = y[n-15] ^ y[n-14]; field at clock c from bits c+11..c+14.
    function automatic int noise_lvl(input int c, input bit is_q);
        bit hi, lo;
        hi = is_q ? narr[c+11] : narr[c+13];
        lo = is_q ? narr[c+12] : narr[c+14];
        if (!hi && lo) return 1;
        if (hi && !lo) return -1;
        return 0;
    endfunction

    function automatic int sat(input int v);
        return (v > 7) ? 7 : ((v < -8) ? -8 : v);
    endfunction

    // Held symbol value after t transmitting edges (zero until the first load).
    function automatic int held(input int t, input bit is_q, input int amp);
        return (t == 0) ? 0 : sym_lvl((t - 1) / SD, is_q, amp);
    endfunction

    int t = 0;
    int c = 0;
    int e3i = 0, e3q = 0, e7i = 0, e7q = 0;
    int s3i = 0, s3q = 0, s7i = 0, s7q = 0;
    int ni = 0, nq = 0;

    always @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            t <= 0; c <= 0;
            e3i <= 0; e3q <= 0; e7i <= 0; e7q <= 0;
            s3i <= 0; s3q <= 0; s7i <= 0; s7q <= 0;
            ni <= 0; nq <= 0;
        end else begin
            c <= c + 1;
            if (is_tx) begin
                t   <= t + 1;
                ni  <= has_error ? noise_lvl(c, 1'b0) : 0;
                nq  <= has_error ? noise_lvl(c, 1'b1) : 0;
                s3i <= held(t, 1'b0, 3); s3q <= held(t, 1'b1, 3);
                s7i <= held(t, 1'b0, 7); s7q <= held(t, 1'b1, 7);
                e3i <= sat(held(t, 1'b0, 3) + (has_error ? noise_lvl(c, 1'b0) : 0));
                e3q <= sat(held(t, 1'b1, 3) + (has_error ? noise_lvl(c, 1'b1) : 0));
                e7i <= sat(held(t, 1'b0, 7) + (has_error ? noise_lvl(c, 1'b0) : 0));
                e7q <= sat(held(t, 1'b1, 7) + (has_error ? noise_lvl(c, 1'b1) : 0));
            end else begin
                e3i <= 0; e3q <= 0; e7i <= 0; e7q <= 0;
                s3i <= 0; s3q <= 0; s7i <= 0; s7q <= 0;
                ni <= 0; nq <= 0;
            end
        end
    end

    always @(negedge sys_clk) begin
        if (chk_en) begin
            int oi, oq, o7i, o7q;
            oi  = int'(if3.channel_outI);
            oq  = int'(if3.channel_outQ);
            o7i = int'(if7.channel_outI);
            o7q = int'(if7.channel_outQ);
            chk("out_I_amp3", oi, e3i);
            chk("out_Q_amp3", oq, e3q);
            chk("out_I_amp7", o7i, e7i);
            chk("out_Q_amp7", o7q, e7q);
            if (phase == 1) begin
                chk("clean_mag_I", iabs(oi), 3);
                chk("clean_mag_Q", iabs(oq), 3);
            end
            if (phase == 2) begin
                chk("err_set_I", int'(iabs(oi) >= 2 && iabs(oi) <= 4), 1);
                chk("err_set_Q", int'(iabs(oq) >= 2 && iabs(oq) <= 4), 1);
                chk("err_dev_I", int'(iabs(oi - s3i) <= 1), 1);
                chk("err_dev_Q", int'(iabs(oq - s3q) <= 1), 1);
            end
            if (cov_en) begin
                if (oi - s3i == 1 || oq - s3q == 1) seen_p = 1'b1;
                if (oi - s3i == -1 || oq - s3q == -1) seen_n = 1'b1;
            end
            if (reset && is_tx) begin
                if (s7i == 7 && ni == 1)   begin chk("sat_hi_I", o7i, 7);  sat_hi_seen = 1'b1; end
                if (s7q == 7 && nq == 1)   begin chk("sat_hi_Q", o7q, 7);  sat_hi_seen = 1'b1; end
                if (s7i == -7 && ni == -1) begin chk("sat_lo_I", o7i, -8); sat_lo_seen = 1'b1; end
                if (s7q == -7 && nq == -1) begin chk("sat_lo_Q", o7q, -8); sat_lo_seen = 1'b1; end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    initial begin
        logic [6:0]  pseed;
        logic [14:0] nseed;
        int lit_i [5];
        int lit_q [5];
        lit_i = '{-3, 3, 3, 3, -3};
        lit_q = '{-3, 3, 3, 3, 3};
        pseed = 7'h7F;
        nseed = 15'h0001;
        for (int i = 0; i < 7; i++)  darr[i] = pseed[6-i];
        for (int i = 7; i < ND; i++) darr[i] = darr[i-7] ^ darr[i-6];
        for (int i = 0; i < 15; i++) narr[i] = nseed[14-i];
        for (int i = 15; i < NN; i++) narr[i] = narr[i-15] ^ narr[i-14];

        // Pin the model against hand-derived values.
        for (int k = 0; k < 5; k++) begin
            chk("model_sym_I", sym_lvl(k, 1'b0, 3), lit_i[k]);
            chk("model_sym_Q", sym_lvl(k, 1'b1, 3), lit_q[k]);
        end
        chk("model_noise_I0", noise_lvl(0, 1'b0), 1);
        chk("model_noise_Q0", noise_lvl(0, 1'b1), 0);
        for (int j = 0; j < 8; j++) begin
            chk("model_period_I", sym_lvl(j + 127, 1'b0, 3), sym_lvl(j, 1'b0, 3));
            chk("model_period_Q", sym_lvl(j + 127, 1'b1, 3), sym_lvl(j, 1'b1, 3));
        end

        #1 reset = 1'b0;
        #1;
        chk("rst_I", int'(if3.channel_outI), 0);
        chk("rst_Q", int'(if3.channel_outQ), 0);
        chk("rst_I7", int'(if7.channel_outI), 0);
        chk("rst_Q7", int'(if7.channel_outQ), 0);
        reset  = 1'b1;
        chk_en = 1'b1;

        step(1);
        chk("first_edge_I", int'(if3.channel_outI), 0);
        for (int k = 0; k < 5; k++) begin
            step((k == 0) ? 1 : SD);
            chk("lit_sym_I", int'(if3.channel_outI), lit_i[k]);
            chk("lit_sym_Q", int'(if3.channel_outQ), lit_q[k]);
        end

        phase = 1;
        step(127 * SD);

        phase = 2;
        has_error = 1'b1;
        seen_p = 1'b0; seen_n = 1'b0;
        cov_en = 1'b1;
        step(64);
        cov_en = 1'b0;
        chk("noise_plus_seen", int'(seen_p), 1);
        chk("noise_minus_seen", int'(seen_n), 1);
        step(136);

        phase = 3;
        for (int k = 0; k < 600; k++) begin
            has_error = 1'($urandom_range(0, 1));
            is_tx     = ($urandom_range(0, 7) != 0);
            step(1);
        end

        phase = 4;
        is_tx = 1'b1; has_error = 1'b0;
        step(6);
        is_tx = 1'b0;
        step(1);
        chk("pause_I", int'(if3.channel_outI), 0);
        chk("pause_Q", int'(if3.channel_outQ), 0);
        step(6);
        is_tx = 1'b1;
        step(24);

        phase = 5;
        step(2);
        @(posedge sys_clk);
        #2 reset = 1'b0;
        #1;
        chk("async_rst_I", int'(if3.channel_outI), 0);
        chk("async_rst_Q", int'(if3.channel_outQ), 0);
        chk("async_rst_I7", int'(if7.channel_outI), 0);
        step(3);
        #1 reset = 1'b1;
        step(2);
        chk("restart_I", int'(if3.channel_outI), -3);
        chk("restart_Q", int'(if3.channel_outQ), -3);
        step(40);

        phase = 6;
        has_error = 1'b1;
        step(300);
        chk("sat_hi_covered", int'(sat_hi_seen), 1);
        chk("sat_lo_covered", int'(sat_lo_seen), 1);

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
